final_w_sender: RTL
===================

# final_w_sender

Reads the two final weight words (w_1_1, w_2_1) from the frame-scheduled weight capture stage and streams them downstream as 32-bit words over a valid/ready handshake. It runs its own frame counter in lockstep with the capture stage, samples both words once per frame inside the capture stage's hold window, and serialises them. A frame is dropped when the previous frame has not drained, and the drop is flagged.

## Interface
Parameters:
- FRAME_LEN, 1026: frame period in cycles; the counter runs 0..FRAME_LEN-1.
- SAMPLE_CYCLE, 64: counter value at which both inputs are sampled. Legal range 62..513, which is inside the capture hold window.
- DROP_W, 8: width of the saturating drop counter.

Ports:
- I_sys_clk, in, 1: system clock.
- I_sys_rstn, in, 1: reset; asynchronous and active-low.
- I_w_1_1_final, in, 32: final w_1_1 from the capture stage.
- I_w_2_1_final, in, 32: final w_2_1 from the capture stage.
- O_data, out, 32: stream word.
- O_valid, out, 1: O_data is valid.
- I_ready, in, 1: downstream accepts the word.
- O_last, out, 1: marks the final word of a frame.
- O_overrun, out, 1: one-cycle pulse when a frame is dropped.
- O_drop_cnt, out, DROP_W: saturating count of dropped frames.

## Operation
- Frame counter `frame_cnt`:
  - Reset value 0.
  - Increments every cycle and wraps from FRAME_LEN-1 to 0.
  - Free-running; it is never stalled by backpressure.
- Sampling: at `frame_cnt == SAMPLE_CYCLE`, the block does one of two things.
  - State IDLE: latch both inputs into `buf0`/`buf1` and move to SEND0.
  - Any other state: assert O_overrun for that cycle, increment O_drop_cnt (saturating at all-ones), leave the buffers unchanged, and keep sending the old frame.
- States:
  - IDLE: O_valid=0.
  - SEND0: O_data=buf0, O_valid=1, O_last=0. Goes to SEND1 on I_ready.
  - SEND1: O_data=buf1, O_valid=1, O_last=1. Goes to IDLE on I_ready.
- Handshake rules:
  - A transfer occurs when O_valid and I_ready are both high at a clock edge.
  - Once O_valid rises, O_data, O_valid and O_last stay stable until the transfer.
  - O_valid never depends combinationally on I_ready.
- Simultaneous events: if the SEND1 transfer completes in the same cycle as `frame_cnt == SAMPLE_CYCLE`, the frame counts as an overrun. The state was not IDLE at that edge.
- Outputs are registered. O_data outside SEND states is 0.
- Reset, including mid-frame or mid-send:
  - `frame_cnt`=0, state=IDLE, buffers=0.
  - O_data=0, O_valid=0, O_last=0, O_overrun=0, O_drop_cnt=0.
  - Any partially sent frame is discarded.

## Timing
- Sample edge: the edge at which `frame_cnt == SAMPLE_CYCLE`.
- O_valid is high from the cycle after the sample edge.
- Minimum frame latency with I_ready held high:
  - w_1_1 transfers 1 cycle after the sample edge.
  - w_2_1 transfers 2 cycles after the sample edge.
  - O_valid drops 3 cycles after the sample edge.
- Throughput: 2 words per frame. Backpressure up to FRAME_LEN-3 cycles per frame causes no drop.
- O_overrun is high for exactly one cycle, the cycle after the sample edge.

## Configuration
- FINAL_W_SENDER_TAG_EN defined:
  - A header state SENDH precedes SEND0.
  - The header word is {16'hA5A5, frame_tag[15:0]}, with O_last=0.
  - `frame_tag` resets to 0 and increments on every sample edge, including dropped frames.
  - The frame becomes 3 words, and every later word slips one cycle.
- FINAL_W_SENDER_TAG_EN undefined: no SENDH state and no `frame_tag` register; frames are 2 words as above.

## Structure
- Shared package `final_w_pkg` holds:
  - the state enum IDLE/SENDH/SEND0/SEND1;
  - the default FRAME_LEN and SAMPLE_CYCLE constants, shared with the capture stage;
  - the header magic 16'hA5A5.
- Sub-module `frame_counter` contains only the wrapping counter and its parameters. The capture stage will reuse it so both stay aligned.
- Everything else stays in this module.

## Test plan
- Reset release, I_ready=1, inputs 32'h1111_1111/32'h2222_2222:
  - Sample edge at frame_cnt=64.
  - Words 1111_1111 then 2222_2222 on consecutive cycles, O_last on the second.
- I_ready=0 for 100 cycles after the sample edge:
  - O_valid and O_data stay stable at 1111_1111.
  - The transfer completes when I_ready rises; no overrun.
- I_ready=0 for 1100 cycles:
  - O_overrun pulses once at the next sample edge and O_drop_cnt=1.
  - The original frame is still sent intact.
- Force 300 consecutive drops with DROP_W=8: O_drop_cnt saturates at 255.
- Assert I_sys_rstn=0 while in SEND1:
  - All outputs go to 0 immediately and state is IDLE.
  - After release, the first word appears 65 cycles later.
- With FINAL_W_SENDER_TAG_EN: over two frames the headers are A5A5_0000 and A5A5_0001, each followed by w_1_1 and w_2_1; O_last is on the w_2_1 word only.

Source files
------------

// File: rtl/final_w_pkg.sv
// final_w_pkg: shared state encoding and frame timing constants
// for the final weight capture/sender pair.
package final_w_pkg;

  localparam int FRAME_LEN_DEF    = 1026;
  localparam int SAMPLE_CYCLE_DEF = 64;

  localparam logic [15:0] HDR_MAGIC = 16'hA5A5;

  typedef enum logic [1:0] {
    IDLE,
    SENDH,
    SEND0,
    SEND1
  } state_t;

endpackage

// File: rtl/final_w_if.sv
// final_w_if: 32-bit valid/ready stream carrying final weights.
// master drives O_data/O_valid/O_last, slave drives I_ready.
interface final_w_if;

  logic [31:0] O_data;
  logic        O_valid;
  logic        I_ready;
  logic        O_last;

  modport master (
    output O_data,
    output O_valid,
    output O_last,
    input  I_ready
  );

  modport slave (
    input  O_data,
    input  O_valid,
    input  O_last,
    output I_ready
  );

endinterface

// File: rtl/frame_counter.sv
// frame_counter: free-running counter 0..FRAME_LEN-1, shared with the
// capture stage so both see the same frame phase. Out: O_cnt.
module frame_counter
  import final_w_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CW        = $clog2(FRAME_LEN)
) (
  input  logic          I_sys_clk,
  input  logic          I_sys_rstn,
  output logic [CW-1:0] O_cnt
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign O_cnt = r_cnt;

endmodule

// File: rtl/final_w_sender.sv
// final_w_sender: samples w_1_1/w_2_1 once per frame and streams them
// on m_if (master); O_overrun/O_drop_cnt flag dropped frames.
// Optional header word: define FINAL_W_SENDER_TAG_EN.
module final_w_sender
  import final_w_pkg::*;
#(
  parameter int FRAME_LEN    = FRAME_LEN_DEF,
  parameter int SAMPLE_CYCLE = SAMPLE_CYCLE_DEF,
  parameter int DROP_W       = 8
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rstn,
  input  logic [31:0]       I_w_1_1_final,
  input  logic [31:0]       I_w_2_1_final,
  final_w_if.master         m_if,
  output logic              O_overrun,
  output logic [DROP_W-1:0] O_drop_cnt
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(SAMPLE_CYCLE);

  logic [CW-1:0]     w_cnt;
  logic              w_sample;
  logic              w_drop;
  logic              w_ready;

  state_t            r_state;
  logic [31:0]       r_buf0;
  logic [31:0]       r_buf1;
  logic [31:0]       r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_overrun;
  logic [DROP_W-1:0] r_drop_cnt;
`ifdef FINAL_W_SENDER_TAG_EN
  logic [15:0]       r_tag;
`endif

  frame_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_cnt (
    .I_sys_clk  (I_sys_clk),
    .I_sys_rstn (I_sys_rstn),
    .O_cnt      (w_cnt)
  );

  assign w_ready  = m_if.I_ready;
  assign w_sample = (w_cnt == SAMPLE_AT);
  // A send finishing on the sample edge still counts as busy.
  assign w_drop   = w_sample && (r_state != IDLE);

  always_ff @(posedge I_sys_clk or negedge I_sys_rstn) begin
    if (!I_sys_rstn) begin
      r_state    <= IDLE;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_overrun  <= 1'b0;
      r_drop_cnt <= '0;
`ifdef FINAL_W_SENDER_TAG_EN
      r_tag      <= '0;
`endif
    end else begin
      r_overrun <= w_drop;
      if (w_drop && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
`ifdef FINAL_W_SENDER_TAG_EN
      if (w_sample) begin
        r_tag <= r_tag + 16'd1;
      end
`endif
      unique case (r_state)
        IDLE: begin
          if (w_sample) begin
            r_buf0  <= I_w_1_1_final;
            r_buf1  <= I_w_2_1_final;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
`ifdef FINAL_W_SENDER_TAG_EN
            r_state <= SENDH;
            r_data  <= {HDR_MAGIC, r_tag};
`else
            r_state <= SEND0;
            r_data  <= I_w_1_1_final;
`endif
          end
        end
`ifdef FINAL_W_SENDER_TAG_EN
        SENDH: begin
          if (w_ready) begin
            r_state <= SEND0;
            r_data  <= r_buf0;
          end
        end
`endif
        SEND0: begin
          if (w_ready) begin
            r_state <= SEND1;
            r_data  <= r_buf1;
            r_last  <= 1'b1;
          end else begin
            r_data  <= r_buf0;
          end
        end
        SEND1: begin
          if (w_ready) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_data  <= '0;
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
      endcase
    end
  end

  assign m_if.O_data  = r_data;
  assign m_if.O_valid = r_valid;
  assign m_if.O_last  = r_last;
  assign O_overrun    = r_overrun;
  assign O_drop_cnt   = r_drop_cnt;

endmodule
